// File: rtl/qspi_read_ctl.sv
// Quad-I/O fast-read (0xEB) sequencer for a SPI flash pin bundle.
// Each requested byte is returned over a valid/ready stream.
module qspi_read_ctl #(
  parameter int          CLKDIV = 1,
  parameter logic [7:0]  CMD    = 8'hEB,
  parameter int          DUMMY  = 4,
  parameter int          LENW   = 12
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req,
  input  logic [23:0]     addr,
  input  logic [LENW-1:0] len,
  output logic            busy,
  output logic            done,
  output logic [7:0]      rd_data,
  output logic            rd_valid,
  input  logic            rd_ready,
  output logic            sclk,
  output logic            cs_n,
  output logic [3:0]      qdo,
  output logic [3:0]      oe,
  input  logic [3:0]      qdi
);

  localparam int              DIVW       = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam int              ENDW       = $clog2(2 * CLKDIV + 1);
  localparam logic [DIVW-1:0] DIV_LAST   = DIVW'(CLKDIV - 1);
  localparam logic [ENDW-1:0] END_LAST   = ENDW'(2 * CLKDIV - 1);
  localparam logic [7:0]      DUMMY_LAST = 8'(DUMMY - 1);
  localparam logic [3:0]      QDO_IDLE   = 4'b1100;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_MODE, S_DUMMY, S_DATA, S_END
  } state_t;

  state_t          state;
  logic [DIVW-1:0] div_cnt;
  logic [ENDW-1:0] end_cnt;
  logic [7:0]      bit_cnt;
  logic [7:0]      cmd_sh;
  logic [23:0]     addr_sh;
  logic [LENW-1:0] cnt;
  logic            nib;
  logic [3:0]      hi_nib;
  logic            shifting;
  logic            stall;
  logic            tick;
  logic            rise;
  logic            fall;

  // A byte's first low phase is held off while the previous byte is unclaimed.
  always_comb begin
    shifting = (state == S_CMD) || (state == S_ADDR) || (state == S_MODE) ||
               (state == S_DUMMY) || (state == S_DATA);
    stall    = (state == S_DATA) && !nib && !sclk && rd_valid && !rd_ready;
    tick     = shifting && !stall && (div_cnt == DIV_LAST);
    rise     = tick && !sclk;
    fall     = tick && sclk;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      sclk     <= 1'b0;
      cs_n     <= 1'b1;
      oe       <= 4'h0;
      qdo      <= QDO_IDLE;
      rd_valid <= 1'b0;
      rd_data  <= 8'h00;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_cnt  <= '0;
      end_cnt  <= '0;
      bit_cnt  <= 8'd0;
      nib      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (rd_valid && rd_ready)
        rd_valid <= 1'b0;

      if (shifting && !stall)
        div_cnt <= tick ? '0 : div_cnt + 1'b1;

      // qdi is captured on the same clk edge that raises sclk.
      if (rise) begin
        sclk <= 1'b1;
        if (state == S_DATA) begin
          if (!nib) begin
            hi_nib <= qdi;
          end else begin
            rd_data  <= {hi_nib, qdi};
            rd_valid <= 1'b1;
          end
        end
      end
      if (fall)
        sclk <= 1'b0;

      case (state)
        S_IDLE: begin
          if (req) begin
            if (len == '0) begin
              done <= 1'b1;
            end else begin
              state   <= S_CMD;
              busy    <= 1'b1;
              cs_n    <= 1'b0;
              oe      <= 4'b1101;
              qdo     <= {3'b110, CMD[7]};
              cmd_sh  <= {CMD[6:0], 1'b0};
              addr_sh <= addr;
              cnt     <= len;
              bit_cnt <= 8'd0;
              div_cnt <= '0;
              nib     <= 1'b0;
            end
          end
        end

        S_CMD: begin
          if (fall) begin
            if (bit_cnt == 8'd7) begin
              state   <= S_ADDR;
              bit_cnt <= 8'd0;
              oe      <= 4'hF;
              qdo     <= addr_sh[23:20];
              addr_sh <= {addr_sh[19:0], 4'h0};
            end else begin
              bit_cnt <= bit_cnt + 8'd1;
              qdo[0]  <= cmd_sh[7];
              cmd_sh  <= {cmd_sh[6:0], 1'b0};
            end
          end
        end

        S_ADDR: begin
          if (fall) begin
            if (bit_cnt == 8'd5) begin
              state   <= S_MODE;
              bit_cnt <= 8'd0;
              qdo     <= 4'h0;
            end else begin
              bit_cnt <= bit_cnt + 8'd1;
              qdo     <= addr_sh[23:20];
              addr_sh <= {addr_sh[19:0], 4'h0};
            end
          end
        end

        // Mode byte 0x00 keeps the flash out of continuous-read mode.
        S_MODE: begin
          if (fall) begin
            if (bit_cnt == 8'd1) begin
              bit_cnt <= 8'd0;
              oe      <= 4'h0;
              qdo     <= 4'h0;
              nib     <= 1'b0;
              state   <= (DUMMY == 0) ? S_DATA : S_DUMMY;
            end else begin
              bit_cnt <= bit_cnt + 8'd1;
            end
          end
        end

        S_DUMMY: begin
          if (fall) begin
            if (bit_cnt == DUMMY_LAST) begin
              state   <= S_DATA;
              bit_cnt <= 8'd0;
              nib     <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt + 8'd1;
            end
          end
        end

        S_DATA: begin
          if (fall) begin
            if (!nib) begin
              nib <= 1'b1;
            end else if (cnt == LENW'(1)) begin
              state   <= S_END;
              cs_n    <= 1'b1;
              qdo     <= QDO_IDLE;
              end_cnt <= '0;
              nib     <= 1'b0;
            end else begin
              cnt <= cnt - 1'b1;
              nib <= 1'b0;
            end
          end
        end

        // Deselect time is guaranteed before done; the last byte must be drained.
        S_END: begin
          if (end_cnt == END_LAST && !rd_valid) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (end_cnt != END_LAST) begin
            end_cnt <= end_cnt + 1'b1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qspi_read_ctl.sv
// Bench for qspi_read_ctl: a behavioural quad-read flash on the pins plus
// table-driven, hand-written and randomized read transactions.
module tb_qspi_read_ctl;

  typedef logic [7:0] bq_t[$];

  typedef struct {
    logic [23:0] a;
    logic [11:0] n;
    int          rmode;
    bit          inject;
    logic [31:0] d;
    int          edges;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic [23:0] addr_i = 24'h0;
  logic [11:0] len_i = 12'h0;
  logic        busy, done;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        rd_ready = 1'b1;
  logic        sclk, cs_n;
  logic [3:0]  qdo, oe;
  logic [3:0]  qdi = 4'h0;

  int checks = 0;
  int errors = 0;

  qspi_read_ctl dut (
    .clk(clk), .rst(rst), .req(req), .addr(addr_i), .len(len_i),
    .busy(busy), .done(done), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .sclk(sclk), .cs_n(cs_n), .qdo(qdo), .oe(oe), .qdi(qdi)
  );

  always #5 clk = ~clk;

  // Flash model: decodes the pins per transaction and serves bytes from fmem.
  logic [7:0]  fmem [0:255];
  int          fl_edges = 0, fl_last_edges = 0, fl_pin_err = 0;
  logic [7:0]  fl_cmd = 8'h0, fl_last_cmd = 8'h0, fl_mode = 8'h0, fl_last_mode = 8'h0;
  logic [23:0] fl_addr = 24'h0, fl_last_addr = 24'h0;
  logic        fl_sclk_q = 1'b0, fl_cs_q = 1'b1;
  logic [3:0]  fl_qdo_q = 4'b1100, fl_oe_q = 4'h0;

  always @(negedge clk) begin
    int idx;
    logic [7:0] ai, b;
    if (!rst && sclk && (qdo !== fl_qdo_q || oe !== fl_oe_q)) fl_pin_err++;
    if (cs_n) begin
      if (!fl_cs_q) begin
        fl_last_edges = fl_edges;
        fl_last_cmd   = fl_cmd;
        fl_last_addr  = fl_addr;
        fl_last_mode  = fl_mode;
      end
      fl_edges = 0;
    end else begin
      if (fl_cs_q) begin
        fl_cmd = 8'h0; fl_addr = 24'h0; fl_mode = 8'h0;
      end
      if (sclk && !fl_sclk_q) begin
        fl_edges++;
        if (fl_edges <= 8) begin
          fl_cmd = {fl_cmd[6:0], qdo[0]};
          if (oe !== 4'b1101 || qdo[3:2] !== 2'b11) fl_pin_err++;
        end else if (fl_edges <= 14) begin
          fl_addr = {fl_addr[19:0], qdo};
          if (oe !== 4'hF) fl_pin_err++;
        end else if (fl_edges <= 16) begin
          fl_mode = {fl_mode[3:0], qdo};
          if (oe !== 4'hF) fl_pin_err++;
        end else if (oe !== 4'h0) begin
          fl_pin_err++;
        end
      end
      if (!sclk && fl_sclk_q && fl_edges >= 20) begin
        idx = (fl_edges - 20) / 2;
        ai  = fl_addr[7:0] + 8'(idx);
        b   = fmem[ai];
        qdi = (((fl_edges - 20) % 2) == 0) ? b[7:4] : b[3:0];
      end
    end
    fl_sclk_q = sclk; fl_cs_q = cs_n; fl_qdo_q = qdo; fl_oe_q = oe;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // rmode 0: always ready; 1: random ready; 2: ready low for 10 clks after first byte.
  task automatic do_read(input logic [23:0] a, input logic [11:0] n, input int rmode,
                         input bit inject, output bq_t got);
    int  dn, dcyc, c0, pe0, last_acc, cyc;
    bit  stall_ok, space_ok;
    got.delete();
    dn = 0; dcyc = 0; c0 = -1; pe0 = fl_pin_err; last_acc = -1;
    stall_ok = 1'b1; space_ok = 1'b1;
    addr_i = a; len_i = n; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    check("busy_after_req", {30'd0, busy, cs_n}, 32'h2);
    for (cyc = 0; cyc < 4000; cyc++) begin
      if (done) begin dn++; dcyc = cyc; end
      if (dn > 0 && cyc >= dcyc + 3) break;
      case (rmode)
        0: rd_ready = 1'b1;
        1: rd_ready = ($urandom_range(0, 3) != 0);
        default: begin
          if (c0 < 0 && rd_valid) c0 = cyc;
          rd_ready = !(c0 >= 0 && cyc < c0 + 10);
          if (c0 >= 0 && cyc >= c0 + 2 && cyc < c0 + 10 && (sclk || cs_n)) stall_ok = 1'b0;
        end
      endcase
      if (rd_valid && rd_ready) begin
        got.push_back(rd_data);
        if (last_acc >= 0 && cyc - last_acc != 4) space_ok = 1'b0;
        last_acc = cyc;
      end
      if (inject && cyc == 12) begin
        addr_i = 24'hABCDEF; len_i = 12'd7; req = 1'b1;
      end else begin
        req = 1'b0;
      end
      @(negedge clk);
    end
    rd_ready = 1'b1;
    check("done_pulses", dn, 1);
    check("byte_count", got.size(), {20'd0, n});
    check("cmd_on_io0", {24'd0, fl_last_cmd}, 32'hEB);
    check("addr_nibbles", {8'd0, fl_last_addr}, {8'd0, a});
    check("mode_byte", {24'd0, fl_last_mode}, 32'h0);
    check("pin_rules", fl_pin_err - pe0, 0);
    if (rmode == 0) check("byte_spacing", {31'd0, space_ok}, 1);
    if (rmode == 2) check("stall_sclk_cs", {31'd0, stall_ok}, 1);
  endtask

  initial begin
    vec_t tbl[4];
    bq_t  got;
    bq_t  exp_q;
    logic [23:0] ra;
    logic [11:0] rn;
    bit   saw_valid, saw_cs;

    tbl[0] = '{a: 24'h012345, n: 12'd1, rmode: 0, inject: 1'b0, d: 32'hA5000000, edges: 22};
    tbl[1] = '{a: 24'h000100, n: 12'd4, rmode: 0, inject: 1'b0, d: 32'h11223344, edges: 28};
    tbl[2] = '{a: 24'h000200, n: 12'd3, rmode: 2, inject: 1'b0, d: 32'hC35A7E00, edges: 26};
    tbl[3] = '{a: 24'hFFFFFE, n: 12'd4, rmode: 1, inject: 1'b1, d: 32'hDEADBEEF, edges: 28};
    for (int i = 0; i < 256; i++) fmem[i] = 8'(i * 37 + 11);

    // Reset state
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_sclk", {31'd0, sclk}, 0);
    check("rst_cs_n", {31'd0, cs_n}, 1);
    check("rst_oe", {28'd0, oe}, 0);
    check("rst_qdo", {28'd0, qdo}, 32'hC);
    check("rst_rd_valid", {31'd0, rd_valid}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    rst = 1'b0;
    @(negedge clk);

    // Directed table
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 4; i++) fmem[8'(tbl[r].a[7:0] + 8'(i))] = tbl[r].d[31-8*i -: 8];
      do_read(tbl[r].a, tbl[r].n, tbl[r].rmode, tbl[r].inject, got);
      check("tbl_sclk_edges", fl_last_edges, tbl[r].edges);
      for (int i = 0; i < int'(tbl[r].n); i++)
        check("tbl_byte", (i < got.size()) ? {24'd0, got[i]} : 32'hFFFF_FFFF,
              {24'd0, tbl[r].d[31-8*i -: 8]});
    end

    // Reset mid-DATA of a len=8 read
    for (int i = 0; i < 256; i++) fmem[i] = 8'($urandom);
    addr_i = 24'h000040; len_i = 12'd8; req = 1'b1;
    @(negedge clk);
    req = 1'b0; rd_ready = 1'b1;
    repeat (50) @(negedge clk);
    check("mid_data_cs_low", {31'd0, cs_n}, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_cs_n", {31'd0, cs_n}, 1);
    check("abort_oe", {28'd0, oe}, 0);
    check("abort_busy", {31'd0, busy}, 0);
    saw_valid = rd_valid;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      saw_valid = saw_valid | rd_valid | !cs_n;
    end
    check("abort_no_byte", {31'd0, saw_valid}, 0);
    do_read(24'h000000, 12'd2, 0, 1'b0, got);
    check("post_abort_b0", (got.size() > 0) ? {24'd0, got[0]} : 32'hFFFF_FFFF, {24'd0, fmem[0]});
    check("post_abort_b1", (got.size() > 1) ? {24'd0, got[1]} : 32'hFFFF_FFFF, {24'd0, fmem[1]});

    // len == 0 is a no-op that still reports done
    addr_i = 24'h111111; len_i = 12'd0; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    check("len0_done", {30'd0, done, busy}, 32'h2);
    saw_cs = !cs_n;
    @(negedge clk);
    saw_cs = saw_cs | !cs_n;
    check("len0_done_drop", {31'd0, done}, 0);
    @(negedge clk);
    saw_cs = saw_cs | !cs_n;
    check("len0_cs_idle", {31'd0, saw_cs}, 0);

    // Randomized transactions against the memory scoreboard
    for (int t = 0; t < 16; t++) begin
      for (int i = 0; i < 256; i++) fmem[i] = 8'($urandom);
      ra = 24'($urandom);
      rn = 12'($urandom_range(1, 6));
      exp_q.delete();
      for (int i = 0; i < int'(rn); i++) exp_q.push_back(fmem[8'(ra[7:0] + 8'(i))]);
      do_read(ra, rn, $urandom_range(0, 1), 1'($urandom_range(0, 1)), got);
      check("rnd_sclk_edges", fl_last_edges, 20 + 2 * int'(rn));
      for (int i = 0; i < exp_q.size(); i++)
        check("rnd_byte", (i < got.size()) ? {24'd0, got[i]} : 32'hFFFF_FFFF, {24'd0, exp_q[i]});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
